// File: rtl/exc_cause_unit.sv
// rtl/exc_cause_unit.sv - exception cause capture, EPC save and handler redirect
// Three-state exception FSM with prioritised causes and a synchronised interrupt input.
module exc_cause_unit #(
    parameter logic [31:0] HANDLER = 32'h0000_0040,
    parameter int          BLINK_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ov,
    input  logic        ri,
    input  logic        sys,
    input  logic        intr,
    input  logic [31:0] pc,
    input  logic        eret,
    input  logic        clr,
    output logic        exc_flush,
    output logic [31:0] exc_vec,
    output logic [31:0] epc,
    output logic [2:0]  causeout,
    output logic        ol,
    output logic        ssled
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_INT  = 3'd1;
    localparam logic [2:0] CAUSE_OV   = 3'd2;
    localparam logic [2:0] CAUSE_RI   = 3'd3;
    localparam logic [2:0] CAUSE_SYS  = 3'd4;

    state_t               state_q, state_d;
    logic [2:0]           cause_q, cause_d;
    logic                 ol_q, ol_d;
    logic [31:0]          epc_q, epc_d;
    logic                 int_pend_q, int_pend_d;
    logic                 sync1_q, sync2_q, sync3_q;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 int_rise;

    assign int_rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        ol_d       = ol_q;
        epc_d      = epc_q;
        int_pend_d = int_pend_q | int_rise;
        exc_flush  = 1'b0;
        exc_vec    = HANDLER;

        if (clr) begin
            cause_d = CAUSE_NONE;
            ol_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ov || ri || sys || int_pend_q) begin
                    state_d = TAKE;
                    if (ov) begin
                        cause_d = CAUSE_OV;
                        epc_d   = pc;
                        ol_d    = 1'b1;
                    end else if (ri) begin
                        cause_d = CAUSE_RI;
                        epc_d   = pc;
                    end else if (sys) begin
                        cause_d = CAUSE_SYS;
                        epc_d   = pc;
                    end else begin
                        // A fresh edge arriving as the old one is taken stays pending.
                        cause_d    = CAUSE_INT;
                        epc_d      = pc + 32'd4;
                        int_pend_d = int_rise;
                    end
                end
            end
            TAKE: begin
                exc_flush = 1'b1;
                state_d   = SERVICE;
            end
            SERVICE: begin
                if (eret) begin
                    exc_flush = 1'b1;
                    exc_vec   = epc_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts at zero on every SERVICE entry and is cleared on exit.
        blink_d = (state_q == SERVICE && state_d == SERVICE)
                ? blink_q + {{(BLINK_W-1){1'b0}}, 1'b1}
                : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cause_q    <= CAUSE_NONE;
            ol_q       <= 1'b0;
            epc_q      <= 32'd0;
            int_pend_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            ol_q       <= ol_d;
            epc_q      <= epc_d;
            int_pend_q <= int_pend_d;
            sync1_q    <= intr;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            blink_q    <= blink_d;
        end
    end

    assign epc      = epc_q;
    assign causeout = cause_q;
    assign ol       = ol_q;
    assign ssled    = blink_q[BLINK_W-1];

endmodule
